// File: rtl/disaster_alert_ctrl.sv
// Disaster alert controller: persistence-filtered hazard detection, sticky alarm latches, and prioritised LED/code outputs.
// Optional LED blinking is enabled by defining DWD_ALERT_BLINK_EN.
module disaster_alert_ctrl #(
    parameter int LVL_W     = 2,
    parameter int RAIN_TH   = 2,
    parameter int WIND_TH   = 2,
    parameter int LVL_TH    = 2,
    parameter int SEIS_TH   = 1,
    parameter int TSU_TH    = 2,
    parameter int PERSIST   = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] rain,
    input  logic [LVL_W-1:0] wind,
    input  logic [LVL_W-1:0] seismic,
    input  logic [LVL_W-1:0] level,
    input  logic             mode,
    input  logic             ack,
    output logic             flood_led,
    output logic             cyclone_led,
    output logic             earthquake_led,
    output logic             tsunami_led,
    output logic [1:0]       alarm_code,
    output logic             alarm_valid
);

    // Hazard slots in priority order; the slot index is also the alarm code.
    localparam int H_FLOOD   = 0;
    localparam int H_CYCLONE = 1;
    localparam int H_QUAKE   = 2;
    localparam int H_TSUNAMI = 3;

    localparam logic [LVL_W-1:0] MAX_LVL  = '1;
    localparam logic [LVL_W-1:0] RAIN_T   = LVL_W'(RAIN_TH);
    localparam logic [LVL_W-1:0] WIND_T   = LVL_W'(WIND_TH);
    localparam logic [LVL_W-1:0] LVL_T    = LVL_W'(LVL_TH);
    localparam logic [LVL_W-1:0] SEIS_T   = LVL_W'(SEIS_TH);
    localparam logic [LVL_W-1:0] TSU_T    = LVL_W'(TSU_TH);
    localparam logic [7:0]       PERSIST_C = 8'(PERSIST);

    logic [3:0] raw;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [3:0] confirm;
    logic [3:0] latch_q, latch_d;
    logic [3:0] top_onehot;
    logic [3:0] led_sel;
    logic [3:0] led_q, led_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;

    always_comb begin
        raw[H_FLOOD]   = (rain >= RAIN_T) &
                         ((wind >= WIND_T) | (level >= LVL_T) | (rain == MAX_LVL));
        raw[H_CYCLONE] = (wind >= WIND_T) &
                         ((wind == MAX_LVL) | (level >= LVL_T) | (rain >= RAIN_T));
        raw[H_QUAKE]   = (seismic >= SEIS_T);
        raw[H_TSUNAMI] = (seismic >= TSU_T) & (level >= LVL_T);
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        for (int i = 0; i < 4; i++) begin
            cnt_d[i]   = '0;
            confirm[i] = 1'b0;
            if (raw[i]) begin
                cnt_d[i]   = (cnt_q[i] == PERSIST_C) ? cnt_q[i] : cnt_q[i] + 8'd1;
                confirm[i] = (cnt_d[i] == PERSIST_C);
            end
        end
        // A confirmation overrides a same-edge acknowledge; ack only drops hazards that have gone quiet.
        latch_d = confirm | (ack ? (latch_q & raw) : latch_q);
    end

    always_comb begin
        top_onehot = 4'b0000;
        code_d     = 2'b00;
        if (latch_q[H_FLOOD]) begin
            top_onehot[H_FLOOD] = 1'b1;
            code_d              = 2'b00;
        end else if (latch_q[H_CYCLONE]) begin
            top_onehot[H_CYCLONE] = 1'b1;
            code_d                = 2'b01;
        end else if (latch_q[H_QUAKE]) begin
            top_onehot[H_QUAKE] = 1'b1;
            code_d              = 2'b10;
        end else if (latch_q[H_TSUNAMI]) begin
            top_onehot[H_TSUNAMI] = 1'b1;
            code_d                = 2'b11;
        end
        valid_d = |latch_q;
        led_sel = mode ? latch_q : top_onehot;
    end

`ifdef DWD_ALERT_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // The phase flips whenever the counter wraps through zero, which includes the first edge out of reset.
    always_comb begin
        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
        phase_d     = (blink_cnt_q == '0) ? ~phase_q : phase_q;
        led_d       = led_sel & {4{phase_d}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign led_d = led_sel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            // NOTE: the counter array is a handful of flops rather than a RAM, so it is reset like any other register.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            latch_q <= '0;
            led_q   <= '0;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            latch_q <= latch_d;
            led_q   <= led_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign flood_led      = led_q[H_FLOOD];
    assign cyclone_led    = led_q[H_CYCLONE];
    assign earthquake_led = led_q[H_QUAKE];
    assign tsunami_led    = led_q[H_TSUNAMI];
    assign alarm_code     = code_q;
    assign alarm_valid    = valid_q;

endmodule

// File: tb/tb_disaster_alert_ctrl.sv
// Directed self-checking bench for disaster_alert_ctrl at default parameters.
// Expected values are hand-derived; outputs are packed as {flood, cyclone, quake, tsunami, code[1:0], valid}.
module tb_disaster_alert_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rain, wind, seismic, level;
    logic       mode, ack;
    logic       flood_led, cyclone_led, earthquake_led, tsunami_led;
    logic [1:0] alarm_code;
    logic       alarm_valid;

    int checks = 0;
    int errors = 0;

    disaster_alert_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rain           (rain),
        .wind           (wind),
        .seismic        (seismic),
        .level          (level),
        .mode           (mode),
        .ack            (ack),
        .flood_led      (flood_led),
        .cyclone_led    (cyclone_led),
        .earthquake_led (earthquake_led),
        .tsunami_led    (tsunami_led),
        .alarm_code     (alarm_code),
        .alarm_valid    (alarm_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {flood_led, cyclone_led, earthquake_led, tsunami_led, alarm_code, alarm_valid};
    endfunction

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [1:0] r, input logic [1:0] w,
                          input logic [1:0] s, input logic [1:0] l);
        rain    = r;
        wind    = w;
        seismic = s;
        level   = l;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        ack   = 1'b0;
        set_in(0, 0, 0, 0);
        #12;
        check("reset_outs", outs(), 7'b0000_00_0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_outs", outs(), 7'b0000_00_0);

        // Flood and cyclone both hold; the edge-3 latch shows on the LEDs after edge 4.
        set_in(2, 2, 0, 0);
        tick(4);
        check("flood_edge3", outs(), 7'b0000_00_0);
        tick();
        check("flood_edge4", outs(), 7'b1000_00_1);
        mode = 1'b1;
        check("mode_before_edge", outs(), 7'b1000_00_1);
        tick();
        check("mode1_all", outs(), 7'b1100_00_1);

        // Acknowledge while the conditions persist, then after they drop.
        set_in(3, 2, 0, 0);
        pulse_ack();
        tick();
        check("ack_held", outs(), 7'b1100_00_1);
        set_in(0, 0, 0, 0);
        ack = 1'b1;
        tick();
        check("ack_lag", outs(), 7'b1100_00_1);
        ack = 1'b0;
        tick();
        check("ack_clear", outs(), 7'b0000_00_0);

        // Acknowledge on the confirmation edge itself.
        mode = 1'b0;
        set_in(2, 2, 0, 0);
        tick(3);
        pulse_ack();
        tick();
        check("ack_on_confirm", outs(), 7'b1000_00_1);
        set_in(0, 0, 0, 0);
        pulse_ack();
        tick();
        check("cleanup1", outs(), 7'b0000_00_0);

        // Seismic blip shorter than the persistence window.
        seismic = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("quake_blip", {31'd0, earthquake_led}, 32'd0);
        end
        seismic = 2'd0;
        tick(6);
        check("quake_blip_end", outs(), 7'b0000_00_0);

        // Earthquake and tsunami together: priority, then show-all.
        set_in(0, 0, 2, 2);
        tick(5);
        check("quake_prio", outs(), 7'b0010_10_1);
        mode = 1'b1;
        tick();
        check("quake_tsu_mode1", outs(), 7'b0011_10_1);
        mode = 1'b0;
        set_in(0, 0, 0, 0);
        pulse_ack();
        tick();
        check("cleanup2", outs(), 7'b0000_00_0);

        // Wind at threshold alone is not a cyclone; wind at max is.
        set_in(0, 2, 0, 0);
        tick(6);
        check("wind_th_only", outs(), 7'b0000_00_0);
        set_in(0, 3, 0, 0);
        tick(5);
        check("cyclone_max", outs(), 7'b0100_01_1);
        set_in(0, 0, 0, 0);
        pulse_ack();
        tick();
        check("cleanup3", outs(), 7'b0000_00_0);

        // Rain at max alone is a flood; adding a cyclone count then resetting mid-persistence.
        set_in(3, 0, 0, 0);
        tick(5);
        check("flood_rain_max", outs(), 7'b1000_00_1);
        wind = 2'd3;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 7'b0000_00_0);
        set_in(0, 3, 0, 0);
        #2;
        rst_n = 1'b1;
        tick(4);
        check("fresh_count4", outs(), 7'b0000_00_0);
        tick();
        check("fresh_count5", outs(), 7'b0100_01_1);

        // Flood held latched: LED blinks or stays steady depending on the build.
        set_in(3, 0, 0, 0);
        tick(5);
        begin
            logic prev;
            int   toggles;
            int   invalid;
            int   dark;
            prev    = flood_led;
            toggles = 0;
            invalid = 0;
            dark    = 0;
            for (int i = 0; i < 32; i++) begin
                tick();
                if (flood_led !== prev) toggles++;
                if (alarm_valid !== 1'b1) invalid++;
                if (flood_led !== 1'b1) dark++;
                prev = flood_led;
            end
            check("blink_valid", invalid, 0);
`ifdef DWD_ALERT_BLINK_EN
            check("blink_toggles", toggles, 4);
`else
            check("steady_toggles", toggles, 0);
            check("steady_dark", dark, 0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
